// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port scheduler: widths, FIFO entry layout, grant source.
package wb_pkg;

  localparam int REG_W  = 3;
  localparam int DATA_W = 16;
  localparam int NREGS  = 1 << REG_W;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO
  } gnt_src_e;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    return NREGS'(1) << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of late load returns; entries can be killed by destination-register match.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  wb_entry_t                   i_push_entry,
  input  logic                        i_pop,
  input  logic                        i_kill_en,
  input  logic [REG_W-1:0]            i_kill_reg,
  output wb_entry_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]  o_count,
  output logic [DEPTH-1:0]            o_live_nxt,
  output logic [DEPTH-1:0][REG_W-1:0] o_reg_nxt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  r_live;
  logic [REG_W-1:0]  r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [DEPTH-1:0]            w_live_nxt;
  logic [DEPTH-1:0][REG_W-1:0] w_reg_nxt;

  // A live bit implies occupancy: popped slots are cleared so the live vector alone drives pend_mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_live_nxt[i] = r_live[i];
      w_reg_nxt[i]  = r_reg[i];
      if (i_kill_en && (r_reg[i] == i_kill_reg)) w_live_nxt[i] = 1'b0;
      if (i_pop && (r_rd_ptr == PTR_W'(i)))      w_live_nxt[i] = 1'b0;
      if (i_push && (r_wr_ptr == PTR_W'(i))) begin
        w_live_nxt[i] = i_push_entry.live;
        w_reg_nxt[i]  = i_push_entry.dst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= '0;
    end else begin
      r_live <= w_live_nxt;
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_reg[r_wr_ptr]  <= i_push_entry.dst;
      r_data[r_wr_ptr] <= i_push_entry.data;
    end
  end

  assign o_head     = {r_live[r_rd_ptr], r_reg[r_rd_ptr], r_data[r_rd_ptr]};
  assign o_count    = r_count;
  assign o_live_nxt = w_live_nxt;
  assign o_reg_nxt  = w_reg_nxt;

endmodule

// File: rtl/wb_port_sched.sv
// Arbitrates the register-file write port between pipeline writeback and buffered late loads.
// Optional WB_BYPASS_EN: a load arriving with nothing else pending goes straight to the write port.
module wb_port_sched
  import wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [REG_W-1:0]  pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_ack,
  output logic              stall_pipe,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [NREGS-1:0]  pend_mask,
  output logic              regwrite,
  output logic [REG_W-1:0]  writereg,
  output logic [DATA_W-1:0] regwritedata
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int WAIT_W = $clog2(MAX_WAIT+1);

  logic [WAIT_W-1:0] r_wait_cnt;

  wb_entry_t                   w_head;
  logic [CNT_W-1:0]            w_count;
  logic [DEPTH-1:0]            w_live_nxt;
  logic [DEPTH-1:0][REG_W-1:0] w_reg_nxt;
  logic                        w_empty;
  logic                        w_head_live;
  gnt_src_e                    w_gnt;
  logic                        w_pop;
  logic                        w_bypass;
  logic                        w_mem_acc;
  logic                        w_push;
  wb_entry_t                   w_push_entry;
  logic [NREGS-1:0]            w_pend_nxt;
  logic                        w_wr_en;
  logic [REG_W-1:0]            w_wr_reg;
  logic [DATA_W-1:0]           w_wr_data;

  assign w_empty     = (w_count == '0);
  assign w_head_live = !w_empty && w_head.live;
  assign stall_pipe  = (r_wait_cnt == WAIT_W'(MAX_WAIT)) && w_head_live;
  assign mem_ready   = (w_count != CNT_W'(DEPTH));

  always_comb begin
    w_gnt = GNT_NONE;
    if (stall_pipe)      w_gnt = GNT_FIFO;
    else if (pipe_valid) w_gnt = GNT_PIPE;
    else if (!w_empty)   w_gnt = GNT_FIFO;
  end

  assign pipe_ack = (w_gnt == GNT_PIPE);
  assign w_pop    = (w_gnt == GNT_FIFO);

`ifdef WB_BYPASS_EN
  assign w_bypass = w_empty && !pipe_valid && !stall_pipe && mem_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A load landing alongside a pipe write to the same register is older, so it is buffered dead.
  assign w_mem_acc    = mem_valid && mem_ready;
  assign w_push       = w_mem_acc && !w_bypass;
  assign w_push_entry = {!(pipe_ack && (mem_reg == pipe_reg)), mem_reg, mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill_en    (pipe_ack),
    .i_kill_reg   (pipe_reg),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_live_nxt   (w_live_nxt),
    .o_reg_nxt    (w_reg_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_pop || w_empty) begin
      r_wait_cnt <= '0;
    end else if (w_head_live && (r_wait_cnt != WAIT_W'(MAX_WAIT))) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live_nxt[i]) w_pend_nxt = w_pend_nxt | reg_onehot(w_reg_nxt[i]);
    end
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_reg  = pipe_reg;
    w_wr_data = pipe_data;
    if (pipe_ack) begin
      w_wr_en = 1'b1;
    end else if (w_pop && w_head.live) begin
      w_wr_en   = 1'b1;
      w_wr_reg  = w_head.dst;
      w_wr_data = w_head.data;
    end else if (w_bypass) begin
      w_wr_en   = 1'b1;
      w_wr_reg  = mem_reg;
      w_wr_data = mem_data;
    end
  end

  // Write-port register stage: one cycle from grant to register-file write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite     <= 1'b0;
      writereg     <= '0;
      regwritedata <= '0;
      pend_mask    <= '0;
    end else begin
      regwrite  <= w_wr_en;
      pend_mask <= w_pend_nxt;
      if (w_wr_en) begin
        writereg     <= w_wr_reg;
        regwritedata <= w_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_sched.sv
// Scoreboard bench for wb_port_sched: queue-based reference model, directed scenarios plus random traffic.
module tb_wb_port_sched;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [2:0]  pipe_reg = '0;
  logic [15:0] pipe_data = '0;
  logic        pipe_ack;
  logic        stall_pipe;
  logic        mem_valid = 1'b0;
  logic [2:0]  mem_reg = '0;
  logic [15:0] mem_data = '0;
  logic        mem_ready;
  logic [7:0]  pend_mask;
  logic        regwrite;
  logic [2:0]  writereg;
  logic [15:0] regwritedata;

  wb_port_sched #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_valid   (pipe_valid),
    .pipe_reg     (pipe_reg),
    .pipe_data    (pipe_data),
    .pipe_ack     (pipe_ack),
    .stall_pipe   (stall_pipe),
    .mem_valid    (mem_valid),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .pend_mask    (pend_mask),
    .regwrite     (regwrite),
    .writereg     (writereg),
    .regwritedata (regwritedata)
  );

  always #5 clk = ~clk;

  typedef struct { bit live; bit [2:0] r; bit [15:0] d; } ent_t;
  typedef struct { bit [2:0] r; bit [15:0] d; } wr_t;

  ent_t       mq[$];
  wr_t        exp_q[$];
  int         wait_m = 0;
  logic [7:0] pend_m = '0;
  int         checks = 0;
  int         failures = 0;
  int         stall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the FIFO is a queue of {live,reg,data}; rules applied straight from the arbitration description.
  task automatic cycle(input logic pv, input logic [2:0] pr, input logic [15:0] pd,
                       input logic mv, input logic [2:0] mr, input logic [15:0] md,
                       input logic r, output bit acc);
    bit   hl, st, rdy, byp;
    int   g;
    int   nw;
    ent_t e;
    @(negedge clk);
    pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    rst = r;
    acc = 0;
    #1;
    if (r) begin
      mq.delete();
      wait_m = 0;
      pend_m = '0;
    end else begin
      hl  = (mq.size() > 0) && mq[0].live;
      st  = (wait_m == MAX_WAIT) && hl;
      rdy = (mq.size() != DEPTH);
      g   = st ? 2 : (pv ? 1 : ((mq.size() > 0) ? 2 : 0));
      byp = 0;
`ifdef WB_BYPASS_EN
      byp = (mq.size() == 0) && !pv && !st && mv;
`endif
      chk("stall_pipe", stall_pipe, st);
      chk("pipe_ack", pipe_ack, (g == 1));
      chk("mem_ready", mem_ready, rdy);
      chk("pend_mask", pend_mask, pend_m);
      if (st) stall_seen++;
      if (g == 2 || mq.size() == 0) nw = 0;
      else if (hl)                   nw = (wait_m + 1 > MAX_WAIT) ? MAX_WAIT : wait_m + 1;
      else                           nw = wait_m;
      if (g == 1) begin
        exp_q.push_back('{r: pr, d: pd});
        foreach (mq[i]) if (mq[i].r == pr) mq[i].live = 0;
      end else if (g == 2) begin
        e = mq.pop_front();
        if (e.live) exp_q.push_back('{r: e.r, d: e.d});
      end
      if (mv && rdy) begin
        acc = 1;
        if (byp) exp_q.push_back('{r: mr, d: md});
        else     mq.push_back('{live: !(g == 1 && mr == pr), r: mr, d: md});
      end
      wait_m = nw;
      pend_m = '0;
      foreach (mq[i]) if (mq[i].live) pend_m[mq[i].r] = 1'b1;
    end
  endtask

  // Monitor: every write-port event must match the oldest expected write, and none may be left behind.
  always @(posedge clk) begin
    wr_t w;
    #1;
    if (regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=reg%0d:%0h required=none at %0t", writereg, regwritedata, $time);
      end else begin
        w = exp_q.pop_front();
        chk("writereg", writereg, w.r);
        chk("regwritedata", regwritedata, w.d);
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_write actual=none required=reg%0d:%0h at %0t", exp_q[0].r, exp_q[0].d, $time);
      exp_q.delete();
    end
  end

  initial begin
    bit          acc;
    bit          mh;
    logic [2:0]  mhr;
    logic [15:0] mhd;
    int          pp;

    cycle(0, 0, 0, 0, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, 0, 0, 1, acc);
    @(negedge clk);
    #1;
    chk("rst_regwrite", regwrite, 0);
    chk("rst_writereg", writereg, 0);
    chk("rst_regwritedata", regwritedata, 0);
    chk("rst_pend_mask", pend_mask, 8'h00);
    chk("rst_mem_ready", mem_ready, 1);

    // Pipe only
    cycle(1, 3, 16'h00A5, 0, 0, 0, 0, acc);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, acc);

    // Late load drain
    cycle(0, 0, 0, 1, 5, 16'h1234, 0, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);

    // Starvation under continuous pipe traffic
    cycle(1, 1, 16'h0100, 1, 2, 16'h2222, 0, acc);
    for (int i = 0; i < 7; i++) cycle(1, 1, 16'(16'h0101 + i), 0, 0, 0, 0, acc);
    chk("starve_stall_seen", stall_seen, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, acc);

    // WAW kill
    cycle(1, 0, 16'h0F0F, 1, 6, 16'hDEAD, 0, acc);
    cycle(1, 6, 16'h0001, 0, 0, 0, 0, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);

    // Full FIFO: memory holds its third return until accepted
    cycle(1, 1, 16'h1111, 1, 3, 16'h3333, 0, acc);
    cycle(1, 1, 16'h1112, 1, 4, 16'h4444, 0, acc);
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) cycle(1, 1, 16'(16'h1200 + i), 1, 7, 16'h7777, 0, acc);
    chk("full_third_accepted", acc, 1);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, acc);

    // Reset mid-operation discards buffered returns
    cycle(1, 1, 16'h5555, 1, 4, 16'hAAAA, 0, acc);
    cycle(1, 2, 16'h5556, 1, 5, 16'hBBBB, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 1, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);

    // Random traffic, increasing pipeline pressure per phase
    mh = 0; mhr = '0; mhd = '0;
    for (int ph = 0; ph < 4; ph++) begin
      pp = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 85 : 100;
      for (int n = 0; n < 700; n++) begin
        if (!mh && ($urandom_range(0, 99) < 55)) begin
          mh  = 1;
          mhr = 3'($urandom_range(0, 7));
          mhd = 16'($urandom);
        end
        cycle(($urandom_range(0, 99) < pp), 3'($urandom_range(0, 7)), 16'($urandom),
              mh, mhr, mhd, ($urandom_range(0, 299) == 0), acc);
        if (acc) mh = 0;
      end
    end

    repeat (12) cycle(0, 0, 0, 0, 0, 0, 0, acc);
    chk("final_fifo_drained", pend_mask, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_sched.md
Name: wb_port_sched

Overview:
- Schedules the single register-file write port between two sources.
  - In-order pipeline writeback: ALU, SLBI, compare-set, BTR and LBI results, already muxed upstream.
  - Late load returns from the multi-cycle data memory.
- Late returns are buffered in a small FIFO and drained when the pipeline does not need the port.
- Starvation is bounded by a wait counter that stalls the pipeline.
- Sits between the writeback mux and the register file; drives the register file's write enable, write register and write data.

Parameters:
- DEPTH, 2, late-return FIFO entries (power of 2, ≥2).
- MAX_WAIT, 4, cycles a valid FIFO head may be passed over before the pipeline is stalled.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high, one clock (clk).
- pipe_valid  in  1  pipeline has a writeback this cycle.
- pipe_reg  in  3  pipeline destination register.
- pipe_data  in  16  pipeline write data.
- pipe_ack  out  1  pipeline writeback granted this cycle (combinational).
- stall_pipe  out  1  pipeline must hold its writeback stage (combinational).
- mem_valid  in  1  late load return offered.
- mem_reg  in  3  load destination register.
- mem_data  in  16  load data.
- mem_ready  out  1  return accepted on this edge when mem_valid=1 (combinational).
- pend_mask  out  8  bit r set while a live FIFO entry targets register r (registered).
- regwrite  out  1  register file write enable (registered).
- writereg  out  3  register file write register (registered).
- regwritedata  out  16  register file write data (registered).

Behaviour:
- Reset: FIFO empty, all entry valid bits 0, wait_cnt=0, pend_mask=0, regwrite=0, writereg=0, regwritedata=0. Reset mid-operation discards all buffered returns with no write.
- FIFO entry = {live, reg[2:0], data[15:0]}.
- mem_ready = (count != DEPTH). A pop in the same cycle does not free space early.
- Grant, evaluated each cycle:
  - stall_pipe = (wait_cnt == MAX_WAIT) and head live.
  - If stall_pipe: FIFO head granted; pipe_ack=0.
  - Else if pipe_valid: pipe granted; pipe_ack=1.
  - Else if FIFO non-empty: head popped. It is written if live, dropped silently if dead.
  - Else: idle.
- Output register loads the granted {reg, data} with regwrite=1 on the next edge; otherwise regwrite=0.
- Latency: pipe grant→regwrite 1 cycle. mem accept→earliest regwrite 2 cycles.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle the head is live and not granted.
  - Clears on head pop or when the FIFO is empty.
- WAW kill: a granted pipe write to register r clears live on every FIFO entry with reg=r (the load is older).
  - A mem return accepted the same cycle with mem_reg=r is enqueued dead.
- pend_mask is recomputed each cycle from the post-edge live entries.
- Full FIFO plus mem_valid: mem_ready=0; the memory holds its return.

Optional Feature:
- WB_BYPASS_EN defined:
  - Condition: FIFO empty, pipe_valid=0, stall_pipe=0 and mem_valid=1.
  - Effect: the mem return goes straight to the output register (regwrite next edge) and is not enqueued. mem accept→regwrite is 1 cycle.
- Undefined: all returns pass through the FIFO (2-cycle minimum).

Decomposition:
- Package wb_pkg:
  - REG_W=3, DATA_W=16.
  - wb_entry_t struct {live, reg, data}.
  - Grant-source enum {GNT_NONE, GNT_PIPE, GNT_FIFO}.
- Sub-module wb_fifo: circular DEPTH-entry buffer.
  - Push/pop with count.
  - Per-entry kill by register match.
  - Exports live/reg vectors for pend_mask.

Test Plan:
- Reset then idle: rst=1 two cycles → regwrite=0, writereg=0, pend_mask=0x00, mem_ready=1.
- Pipe only: pipe_valid, reg=3, data=0x00A5 → pipe_ack=1 same cycle; next cycle regwrite=1, writereg=3, regwritedata=0x00A5.
- Late load drain: mem_valid, reg=5, data=0x1234, pipe idle → pend_mask=0x20. Write lands 2 cycles after accept (1 with WB_BYPASS_EN), then pend_mask=0x00.
- Starvation: load reg=2 buffered, pipe_valid held continuously.
  - After 4 passed-over cycles: stall_pipe=1, pipe_ack=0, FIFO write of reg 2.
  - Following cycle: pipe_ack=1.
- WAW kill: load reg=6 buffered, then pipe writes reg=6 data=0x0001 → pend_mask bit6 clears. Only 0x0001 is ever written to reg 6.
- Full FIFO: two loads buffered under continuous pipe traffic → third mem_valid sees mem_ready=0 until a pop edge completes.
